// File: rtl/sram_arbiter_ctrl.sv
// Two-requester (fetch/memory), two-chip (base/ext) asynchronous SRAM controller.
// One channel FSM per chip; memory stage has priority on a shared chip.

module sram_arbiter_chan #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PADDR_W = 20,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_req,
  input  logic                 if_req,
  input  logic                 mem_we,
  input  logic [DATA_W/8-1:0]  mem_be,
  input  logic [PADDR_W-1:0]   mem_paddr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic [PADDR_W-1:0]   if_paddr,
  output logic                 ce_n,
  output logic                 oe_n,
  output logic                 we_n,
  output logic [DATA_W/8-1:0]  be_n,
  output logic                 data_t,
  output logic [PADDR_W-1:0]   paddr,
  output logic [DATA_W-1:0]    wdata,
  output logic                 own_mem,
  output logic                 fin_c,
  output logic                 rd_fin_c
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_REC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [BE_W-1:0]  be_q, be_nxt;
  logic             grant_mem, grant_if;

  // Grant, wait-state counting and completion flags
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    fin_c     = 1'b0;
    rd_fin_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_req) begin
          grant_mem = 1'b1;
          state_nxt = mem_we ? S_WR : S_RD;
          cnt_nxt   = '0;
        end else if (if_req) begin
          grant_if  = 1'b1;
          state_nxt = S_RD;
          cnt_nxt   = '0;
        end
      end
      S_RD: begin
        if (cnt == CNT_W'(RD_WAIT)) begin
          state_nxt = S_DONE;
          fin_c     = 1'b1;
          rd_fin_c  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_WR: begin
        if (cnt == CNT_W'(WR_WAIT)) state_nxt = S_REC;
        else cnt_nxt = cnt + CNT_W'(1);
      end
      S_REC: begin
        state_nxt = S_DONE;
        fin_c     = 1'b1;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    be_nxt = grant_mem ? mem_be : be_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Transaction capture and registered SRAM pins, decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      be_q    <= '0;
      own_mem <= 1'b0;
      paddr   <= '0;
      wdata   <= '0;
      ce_n    <= 1'b1;
      oe_n    <= 1'b1;
      we_n    <= 1'b1;
      be_n    <= '1;
      data_t  <= 1'b0;
    end else begin
      if (grant_mem) begin
        be_q    <= mem_be;
        own_mem <= 1'b1;
        paddr   <= mem_paddr;
        wdata   <= mem_wdata;
      end else if (grant_if) begin
        be_q    <= '0;
        own_mem <= 1'b0;
        paddr   <= if_paddr;
      end
      ce_n   <= !((state_nxt == S_RD) || (state_nxt == S_WR) || (state_nxt == S_REC));
      oe_n   <= (state_nxt != S_RD);
      we_n   <= !((state_nxt == S_WR) && (|be_nxt));
      data_t <= (state_nxt == S_WR) || (state_nxt == S_REC);
      case (state_nxt)
        S_RD:         be_n <= '0;
        S_WR, S_REC:  be_n <= ~be_nxt;
        default:      be_n <= '1;
      endcase
    end
  end
endmodule

module sram_arbiter_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PADDR_W = 20,
  parameter int unsigned SEL_BIT = 22,
  parameter int unsigned RD_WAIT = 1,
  parameter int unsigned WR_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [31:0]          if_addr,
  output logic                 if_rdy,
  output logic [DATA_W-1:0]    if_rdata,
  input  logic                 mem_req,
  input  logic                 mem_we,
  input  logic [DATA_W/8-1:0]  mem_be,
  input  logic [31:0]          mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_rdy,
  output logic [DATA_W-1:0]    mem_rdata,
  input  logic [DATA_W-1:0]    base_rdata,
  output logic [DATA_W-1:0]    base_wdata,
  output logic                 base_data_t,
  output logic [PADDR_W-1:0]   base_paddr,
  output logic                 base_ce_n,
  output logic                 base_oe_n,
  output logic                 base_we_n,
  output logic [DATA_W/8-1:0]  base_be_n,
  input  logic [DATA_W-1:0]    ext_rdata,
  output logic [DATA_W-1:0]    ext_wdata,
  output logic                 ext_data_t,
  output logic [PADDR_W-1:0]   ext_paddr,
  output logic                 ext_ce_n,
  output logic                 ext_oe_n,
  output logic                 ext_we_n,
  output logic [DATA_W/8-1:0]  ext_be_n
);
  logic [PADDR_W-1:0] if_paddr, mem_paddr;
  logic               if_ext, mem_ext;
  logic               b_own_mem, b_fin_c, b_rd_fin_c;
  logic               e_own_mem, e_fin_c, e_rd_fin_c;
  logic               unused_addr_bits;

  assign if_paddr         = if_addr[PADDR_W+1:2];
  assign mem_paddr        = mem_addr[PADDR_W+1:2];
  assign if_ext           = if_addr[SEL_BIT];
  assign mem_ext          = mem_addr[SEL_BIT];
  assign unused_addr_bits = ^{if_addr, mem_addr};

  sram_arbiter_chan #(
    .DATA_W(DATA_W), .PADDR_W(PADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
  ) u_base (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req & ~mem_ext), .if_req(if_req & ~if_ext),
    .mem_we(mem_we), .mem_be(mem_be), .mem_paddr(mem_paddr), .mem_wdata(mem_wdata),
    .if_paddr(if_paddr),
    .ce_n(base_ce_n), .oe_n(base_oe_n), .we_n(base_we_n), .be_n(base_be_n),
    .data_t(base_data_t), .paddr(base_paddr), .wdata(base_wdata),
    .own_mem(b_own_mem), .fin_c(b_fin_c), .rd_fin_c(b_rd_fin_c)
  );

  sram_arbiter_chan #(
    .DATA_W(DATA_W), .PADDR_W(PADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
  ) u_ext (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req & mem_ext), .if_req(if_req & if_ext),
    .mem_we(mem_we), .mem_be(mem_be), .mem_paddr(mem_paddr), .mem_wdata(mem_wdata),
    .if_paddr(if_paddr),
    .ce_n(ext_ce_n), .oe_n(ext_oe_n), .we_n(ext_we_n), .be_n(ext_be_n),
    .data_t(ext_data_t), .paddr(ext_paddr), .wdata(ext_wdata),
    .own_mem(e_own_mem), .fin_c(e_fin_c), .rd_fin_c(e_rd_fin_c)
  );

  // A requester is active on at most one chip, so the two channels never collide here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdy    <= 1'b0;
      mem_rdy   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_rdy  <= (b_fin_c & ~b_own_mem) | (e_fin_c & ~e_own_mem);
      mem_rdy <= (b_fin_c & b_own_mem) | (e_fin_c & e_own_mem);
      if (b_rd_fin_c && !b_own_mem)      if_rdata <= base_rdata;
      else if (e_rd_fin_c && !e_own_mem) if_rdata <= ext_rdata;
      if (b_rd_fin_c && b_own_mem)       mem_rdata <= base_rdata;
      else if (e_rd_fin_c && e_own_mem)  mem_rdata <= ext_rdata;
    end
  end
endmodule
